// File: rtl/sha256_padder.sv
// sha256_padder: SHA-256 message padder that packs a 32-bit big-endian word stream into 512-bit chunks.
// Latency: a chunk is valid one cycle after the edge that accepts its 16th word or the message's last word.
// Backpressure: in_rdy drops while a chunk is held for chunk_rdy. No input is taken while an extra padding chunk is pending.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   in_vld/in_rdy      input word handshake
//   in_data            message word, byte 0 in [31:24]
//   in_last/in_bytes   final word marker and its left-justified byte count (0..4; values >4 are read as 4)
//   chunk_vld/rdy      output chunk handshake
//   chunk_data         16 x 32-bit chunk; index 0 is the first word of the chunk
//   chunk_last         chunk carries the message length (final chunk of the message)
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              chunk_vld,
  input  logic              chunk_rdy,
  output logic [15:0][31:0] chunk_data,
  output logic              chunk_last
);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          widx_q;
  logic [LEN_W-1:0]    byte_cnt_q;
  logic [15:0][31:0]   data_q;
  logic                pend_extra_q;
  logic                extra_term_q;
  logic                last_q;

  logic                in_acc;
  logic                out_acc;
  logic [2:0]          n_bytes;
  logic                full_last;
  logic [4:0]          term_idx;
  logic [LEN_W-1:0]    byte_cnt_last;
  logic [LEN_W-1:0]    len_last;
  logic [LEN_W-1:0]    len_cur;
  logic [63:0]         len_last64;
  logic [63:0]         len_cur64;
  logic [31:0]         last_word;
  logic [15:0][31:0]   last_buf;
  logic [15:0][31:0]   extra_buf;

  assign in_rdy     = (state_q == FILL);
  assign chunk_vld  = (state_q == EMIT);
  assign chunk_data = data_q;
  assign chunk_last = last_q;

  assign in_acc  = in_vld & in_rdy;
  assign out_acc = chunk_vld & chunk_rdy;

  // Byte counts above 4 saturate to a full word.
  assign n_bytes   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign full_last = (n_bytes == 3'd4);
  // A full last word pushes the 0x80 terminator into the following word.
  assign term_idx  = {1'b0, widx_q} + {4'd0, full_last};

  assign byte_cnt_last = byte_cnt_q + LEN_W'(n_bytes);
  assign len_last      = byte_cnt_last << 3;
  assign len_cur       = byte_cnt_q << 3;
  assign len_last64    = 64'(len_last);
  assign len_cur64     = 64'(len_cur);

  // Keep the valid bytes of the last word, place 0x80 right after them, zero the rest.
  always_comb begin
    last_word = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n_bytes) begin
        last_word[31-8*b -: 8] = in_data[31-8*b -: 8];
      end else if (3'(b) == n_bytes) begin
        last_word[31-8*b -: 8] = 8'h80;
      end
    end
  end

  // Buffer image after accepting the last word: earlier words are kept, the
  // current word is masked, and everything after it is zero apart from a
  // possible spilled terminator. The length goes in words 14/15 only when
  // the terminator landed at or before word 13.
  always_comb begin
    last_buf = data_q;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) == {1'b0, widx_q}) begin
        last_buf[i] = last_word;
      end else if (5'(i) > {1'b0, widx_q}) begin
        last_buf[i] = (full_last && (5'(i) == term_idx)) ? 32'h8000_0000 : 32'd0;
      end
    end
    if (term_idx <= 5'd13) begin
      last_buf[14] = len_last64[63:32];
      last_buf[15] = len_last64[31:0];
    end
  end

  // Extra chunk: holds the terminator only if it did not fit into the data chunk.
  always_comb begin
    extra_buf     = '0;
    extra_buf[0]  = extra_term_q ? 32'h8000_0000 : 32'd0;
    extra_buf[14] = len_cur64[63:32];
    extra_buf[15] = len_cur64[31:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (in_acc && (in_last || (widx_q == 4'd15))) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_acc && !pend_extra_q) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx_q       <= 4'd0;
      byte_cnt_q   <= '0;
      data_q       <= '0;
      pend_extra_q <= 1'b0;
      extra_term_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_acc) begin
            if (in_last) begin
              byte_cnt_q <= byte_cnt_last;
              data_q     <= last_buf;
              widx_q     <= 4'd0;
              if (term_idx <= 5'd13) begin
                last_q       <= 1'b1;
                pend_extra_q <= 1'b0;
              end else begin
                last_q       <= 1'b0;
                pend_extra_q <= 1'b1;
                extra_term_q <= (term_idx == 5'd16);
              end
            end else begin
              data_q[widx_q] <= in_data;
              byte_cnt_q     <= byte_cnt_q + LEN_W'(4);
              // Wraps from 15 back to 0 as the full chunk moves to EMIT.
              widx_q         <= widx_q + 4'd1;
              last_q         <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_acc) begin
            if (pend_extra_q) begin
              data_q       <= extra_buf;
              last_q       <= 1'b1;
              pend_extra_q <= 1'b0;
            end else begin
              data_q <= '0;
              widx_q <= 4'd0;
              last_q <= 1'b0;
              if (last_q) begin
                byte_cnt_q <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed bench for sha256_padder with hand-computed chunk contents.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
// Chunk handshakes are performed one at a time by the receive task.
module tb_sha256_padder;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [31:0]       in_data = 32'd0;
  logic              in_last = 1'b0;
  logic [2:0]        in_bytes = 3'd0;
  logic              chunk_vld;
  logic              chunk_rdy = 1'b0;
  logic [15:0][31:0] chunk_data;
  logic              chunk_last;

  int checks = 0;
  int failures = 0;

  logic [15:0][31:0] got_d;
  logic              got_l;

  sha256_padder #(.LEN_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .chunk_vld  (chunk_vld),
    .chunk_rdy  (chunk_rdy),
    .chunk_data (chunk_data),
    .chunk_last (chunk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return {8'(i), 8'h5A, 8'(i + 1), 8'hC3};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_bytes = b;
    in_vld   = 1'b1;
    while (!in_rdy && n < 100) begin
      cyc();
      n++;
    end
    if (!in_rdy) check("send_timeout", {31'd0, in_rdy}, 32'd1);
    cyc();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv();
    int n;
    n = 0;
    while (!chunk_vld && n < 100) begin
      cyc();
      n++;
    end
    if (!chunk_vld) check("recv_timeout", {31'd0, chunk_vld}, 32'd1);
    got_d = chunk_data;
    got_l = chunk_last;
    chunk_rdy = 1'b1;
    cyc();
    chunk_rdy = 1'b0;
  endtask

  task automatic zeros(input string tag, input int lo, input int hi);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = lo; i <= hi; i++) acc = acc | got_d[i];
    check(tag, acc, 32'd0);
  endtask

  task automatic check_abc(input string tag);
    check({tag, "_w0"}, got_d[0], 32'h6162_6380);
    zeros({tag, "_w1_14"}, 1, 14);
    check({tag, "_w15"}, got_d[15], 32'h0000_0018);
    check({tag, "_last"}, {31'd0, got_l}, 32'd1);
  endtask

  initial begin
    // Reset state.
    repeat (3) cyc();
    check("rst_vld", {31'd0, chunk_vld}, 32'd0);
    check("rst_last", {31'd0, chunk_last}, 32'd0);
    check("rst_data", {31'd0, |chunk_data}, 32'd0);
    rst = 1'b1;
    cyc();
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);

    // chunk_rdy high while nothing is valid must not disturb anything.
    chunk_rdy = 1'b1;
    repeat (3) cyc();
    chunk_rdy = 1'b0;
    check("idle_rdy_vld", {31'd0, chunk_vld}, 32'd0);
    check("idle_rdy_in_rdy", {31'd0, in_rdy}, 32'd1);

    // "abc".
    send(32'h6162_6300, 1'b1, 3'd3);
    check("abc_latency", {31'd0, chunk_vld}, 32'd1);
    check("abc_in_rdy_low", {31'd0, in_rdy}, 32'd0);
    recv();
    check_abc("abc");
    check("abc_vld_drop", {31'd0, chunk_vld}, 32'd0);
    check("abc_in_rdy_back", {31'd0, in_rdy}, 32'd1);

    // Empty message; the data bytes must be ignored.
    send(32'hDEAD_BEEF, 1'b1, 3'd0);
    recv();
    check("empty_w0", got_d[0], 32'h8000_0000);
    zeros("empty_w1_15", 1, 15);
    check("empty_last", {31'd0, got_l}, 32'd1);

    // 55 bytes: 13 words plus 3 bytes.
    for (int i = 0; i < 13; i++) send(pat(i), 1'b0, 3'd4);
    send(32'h1122_3344, 1'b1, 3'd3);
    recv();
    check("b55_w0", got_d[0], pat(0));
    check("b55_w12", got_d[12], pat(12));
    check("b55_w13", got_d[13], 32'h1122_3380);
    check("b55_w14", got_d[14], 32'd0);
    check("b55_w15", got_d[15], 32'h0000_01B8);
    check("b55_last", {31'd0, got_l}, 32'd1);

    // 56 bytes: terminator spills to word 14, length needs an extra chunk.
    for (int i = 0; i < 13; i++) send(pat(i), 1'b0, 3'd4);
    send(32'h1122_3344, 1'b1, 3'd4);
    recv();
    check("b56a_w13", got_d[13], 32'h1122_3344);
    check("b56a_w14", got_d[14], 32'h8000_0000);
    check("b56a_w15", got_d[15], 32'd0);
    check("b56a_last", {31'd0, got_l}, 32'd0);
    check("b56_extra_vld", {31'd0, chunk_vld}, 32'd1);
    check("b56_extra_in_rdy", {31'd0, in_rdy}, 32'd0);
    recv();
    zeros("b56b_w0_14", 0, 14);
    check("b56b_w15", got_d[15], 32'h0000_01C0);
    check("b56b_last", {31'd0, got_l}, 32'd1);

    // 64 bytes, last word flagged with in_bytes=7 (read as 4).
    for (int i = 0; i < 15; i++) send(pat(i), 1'b0, 3'd4);
    send(32'h99AA_BBCC, 1'b1, 3'd7);
    recv();
    check("b64a_w0", got_d[0], pat(0));
    check("b64a_w15", got_d[15], 32'h99AA_BBCC);
    check("b64a_last", {31'd0, got_l}, 32'd0);
    recv();
    check("b64b_w0", got_d[0], 32'h8000_0000);
    zeros("b64b_w1_14", 1, 14);
    check("b64b_w15", got_d[15], 32'h0000_0200);
    check("b64b_last", {31'd0, got_l}, 32'd1);

    // 128 bytes back to back; length must restart from zero.
    for (int i = 0; i < 32; i++) begin
      send(pat(i), (i == 31), 3'd4);
      if (i == 15) begin
        recv();
        check("b128a_w0", got_d[0], pat(0));
        check("b128a_w15", got_d[15], pat(15));
        check("b128a_last", {31'd0, got_l}, 32'd0);
      end
    end
    recv();
    check("b128b_w0", got_d[0], pat(16));
    check("b128b_w15", got_d[15], pat(31));
    check("b128b_last", {31'd0, got_l}, 32'd0);
    recv();
    check("b128c_w0", got_d[0], 32'h8000_0000);
    zeros("b128c_w1_14", 1, 14);
    check("b128c_w15", got_d[15], 32'h0000_0400);
    check("b128c_last", {31'd0, got_l}, 32'd1);

    // Backpressure: hold chunk_rdy low for 10 cycles.
    send(32'h6162_6300, 1'b1, 3'd3);
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("bp_vld", {31'd0, chunk_vld}, 32'd1);
      check("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("bp_w0", chunk_data[0], 32'h6162_6380);
      check("bp_w15", chunk_data[15], 32'h0000_0018);
    end

    // Reset mid-EMIT.
    rst = 1'b0;
    #1;
    check("rst_emit_vld", {31'd0, chunk_vld}, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_emit_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("rst_emit_vld_after", {31'd0, chunk_vld}, 32'd0);

    // Reset mid-message, then "abc" must carry only its own length.
    for (int i = 0; i < 3; i++) send(pat(i), 1'b0, 3'd4);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_msg_vld", {31'd0, chunk_vld}, 32'd0);
    send(32'h6162_6300, 1'b1, 3'd3);
    recv();
    check_abc("abc2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream stage of the SHA-256 transform.
- Accepts a big-endian 32-bit word stream for one message and emits 512-bit chunks (16 x 32-bit words) on a valid/ready handshake. These drive the transform's chunk_data input.
- Applies standard SHA-256 padding: a 0x80 terminator byte, zero fill, and a 64-bit big-endian bit length.
- Flags the final chunk of each message.

Parameters:
- LEN_W, 64, width of the message bit-length counter; the count wraps modulo 2^LEN_W.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_vld  in  1  input word valid.
- in_rdy  out  1  padder can accept an input word.
- in_data  in  32  message bytes, big-endian; byte 0 is in [31:24].
- in_last  in  1  final word of the message.
- in_bytes  in  3  valid bytes in a last word, 0..4, left-justified; ignored when in_last=0 (the word is treated as 4 bytes).
- chunk_vld  out  1  chunk_data valid.
- chunk_rdy  in  1  downstream accepts the chunk.
- chunk_data  out  16x32  chunk words; index 0 is message word 0 of the chunk.
- chunk_last  out  1  chunk is the final padded chunk of the message.

Behaviour:
- Reset (rst=0, asynchronous): state=FILL, word index widx=0, byte count=0, buffer all zero, chunk_vld=0, chunk_last=0, chunk_data=0, pend_extra=0. in_rdy=1 from the first cycle after rst deasserts.
- in_rdy is a pure decode: in_rdy = (state==FILL). Input transfers on in_vld&in_rdy; chunk transfers on chunk_vld&chunk_rdy.
- FILL, non-last word accepted:
  - buf[widx] <= in_data; byte count += 4; widx++.
  - If widx was 15: state->EMIT, chunk_last=0, widx->0.
  - chunk_vld goes high the cycle after the 16th word is accepted.
- FILL, last word accepted (n = min(in_bytes,4)):
  - Byte count += n; L = final byte count * 8.
  - buf[widx] <= in_data with bytes >= n zeroed. If n<4, byte n of that word = 0x80.
  - Terminator word index t = widx + (n==4). All words after the terminator are zeroed.
  - t<=13: buf[14]=L[63:32], buf[15]=L[31:0], chunk_last=1, state->EMIT.
  - t in 14..15: buf[t]=0x80000000 if n==4, rest zero. pend_extra=1, chunk_last=0, state->EMIT.
  - t==16: buffer holds 16 data words. pend_extra=1 with extra_term=1, chunk_last=0, state->EMIT.
- EMIT:
  - chunk_vld=1. chunk_data and chunk_last are held stable until the handshake.
  - On handshake with pend_extra=1: buffer loads the extra chunk. Word 0 = 0x80000000 if extra_term else 0; words 1..13 = 0; words 14/15 = L. chunk_last=1, pend_extra=0, stay in EMIT. The extra chunk is valid the next cycle.
  - On handshake with pend_extra=0: chunk_vld=0 the next cycle and state->FILL with widx=0. If chunk_last was set, the byte count clears and the buffer clears. Otherwise the buffer clears for the next chunk.
- Latency: first output chunk is valid 1 cycle after the accepting edge of the 16th word or the last word.
- Throughput: input stalls while in EMIT; at most one chunk is in flight. No input is accepted during the extra chunk.
- Boundaries:
  - Empty message (in_last with in_bytes=0 at widx=0): chunk = 0x80000000, zeros, L=0.
  - in_bytes>4 on a last word is treated as 4.
  - in_last at widx=15 with n==4 follows the t==16 case.
  - chunk_rdy held high while chunk_vld is low has no effect.
  - Reset mid-message or mid-EMIT discards all state immediately; no partial chunk is emitted after reset.

Test Plan:
- "abc": one word 0x61626300, in_last=1, in_bytes=3 -> one chunk: w0=0x61626380, w1..w14=0, w15=0x00000018, chunk_last=1.
- Empty message: in_last=1, in_bytes=0 -> one chunk: w0=0x80000000, w1..w15=0, chunk_last=1.
- 55 bytes (13 full words + last with in_bytes=3) -> single chunk, w13 low byte=0x80, w14=0, w15=0x000001B8, chunk_last=1.
- 56 bytes (14 words, last in_bytes=4) -> chunk A: w14=0x80000000, w15=0, chunk_last=0. Chunk B: w0..w14=0, w15=0x000001C0, chunk_last=1.
- 64 bytes (16 words, last in_bytes=4) -> chunk A: all data, chunk_last=0. Chunk B: w0=0x80000000, w15=0x00000200, chunk_last=1. Then 128-byte message back-to-back -> 3 chunks, final w15=0x00000400.
- Backpressure and reset:
  - chunk_rdy held low 10 cycles -> chunk_vld and chunk_data stable; in_rdy=0 throughout.
  - Assert rst mid-EMIT -> chunk_vld=0 and in_rdy=1 after release.
  - Subsequent "abc" -> correct single chunk with L=0x18.
